// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   BCD stopwatch core. Counts 0.01 s ticks from the clock-division timer as
//   MM:SS.cc, applies start/stop, clear and lap (display freeze) commands and
//   presents a packed 6-digit BCD value to the display/scan logic.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   tick        0.01 s strobe, one clk wide
//   start_stop  command pulse: toggle run/pause (IDLE -> RUN)
//   clear       command pulse: zero count, snapshot, overflow, freeze
//               (honoured in IDLE and PAUSE, ignored in RUN)
//   lap         command pulse: toggle display freeze (RUN/PAUSE only)
//   disp        {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones}
//   running     high in RUN
//   frozen      high while disp shows the lap snapshot
//   overflow    sticky, set when the count wraps past MIN_MAX:59.99
//   sec_pulse   one-cycle strobe after each seconds increment
//   state_o     current FSM state, for observation
//
// Handshake: there is no valid/ready pair. Every input is a single-cycle
// pulse sampled on each rising clk edge; a level held for k cycles is k
// commands. Outputs are registered (disp is a mux between two registers).
module stopwatch_counter #(
  parameter int MIN_MAX = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] disp,
  output logic        running,
  output logic        frozen,
  output logic        overflow,
  output logic        sec_pulse,
  output logic [1:0]  state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] MAX_TENS = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(MIN_MAX % 10);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cs1_q, cs10_q, s1_q, s10_q, m1_q, m10_q;
  logic [3:0]  cs1_d, cs10_d, s1_d, s10_d, m1_d, m10_d;
  logic [23:0] snap_q, snap_d;
  logic        frozen_q, frozen_d;
  logic        ovf_q, ovf_d;
  logic        sec_q, sec_d;

  logic        count_en;
  logic        clear_acc;
  logic        lap_acc;
  logic        at_max;
  logic [23:0] count_d;

  // Ticks count only when the state before the edge is RUN, so a tick that
  // coincides with leaving RUN is counted and one entering RUN is not.
  assign count_en  = tick && (state_q == ST_RUN);
  assign clear_acc = clear && (state_q != ST_RUN);
  assign lap_acc   = lap && (state_q != ST_IDLE);
  assign at_max    = (m10_q == MAX_TENS) && (m1_q == MAX_ONES);

  // Next-state FSM; clear has priority over start_stop.
  always_comb begin
    state_d = state_q;
    if (clear_acc) begin
      state_d = ST_IDLE;
    end else if (start_stop) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // BCD ripple increment; carries propagate cs -> s -> m.
  always_comb begin
    cs1_d  = cs1_q;
    cs10_d = cs10_q;
    s1_d   = s1_q;
    s10_d  = s10_q;
    m1_d   = m1_q;
    m10_d  = m10_q;
    ovf_d  = ovf_q;
    sec_d  = 1'b0;
    if (count_en) begin
      if (cs1_q != 4'd9) begin
        cs1_d = cs1_q + 4'd1;
      end else begin
        cs1_d = 4'd0;
        if (cs10_q != 4'd9) begin
          cs10_d = cs10_q + 4'd1;
        end else begin
          cs10_d = 4'd0;
          sec_d  = 1'b1;
          if (s1_q != 4'd9) begin
            s1_d = s1_q + 4'd1;
          end else begin
            s1_d = 4'd0;
            if (s10_q != 4'd5) begin
              s10_d = s10_q + 4'd1;
            end else begin
              s10_d = 4'd0;
              if (at_max) begin
                // Wrap past the top minute: everything back to zero.
                m1_d  = 4'd0;
                m10_d = 4'd0;
                ovf_d = 1'b1;
              end else if (m1_q != 4'd9) begin
                m1_d = m1_q + 4'd1;
              end else begin
                m1_d  = 4'd0;
                m10_d = m10_q + 4'd1;
              end
            end
          end
        end
      end
    end
    if (clear_acc) begin
      cs1_d  = 4'd0;
      cs10_d = 4'd0;
      s1_d   = 4'd0;
      s10_d  = 4'd0;
      m1_d   = 4'd0;
      m10_d  = 4'd0;
      ovf_d  = 1'b0;
    end
  end

  assign count_d = {m10_d, m1_d, s10_d, s1_d, cs10_d, cs1_d};

  // Lap: freezing captures the post-edge count, so a same-cycle tick is in it.
  always_comb begin
    snap_d   = snap_q;
    frozen_d = frozen_q;
    if (clear_acc) begin
      snap_d   = 24'd0;
      frozen_d = 1'b0;
    end else if (lap_acc) begin
      if (!frozen_q) begin
        snap_d   = count_d;
        frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cs1_q    <= 4'd0;
      cs10_q   <= 4'd0;
      s1_q     <= 4'd0;
      s10_q    <= 4'd0;
      m1_q     <= 4'd0;
      m10_q    <= 4'd0;
      snap_q   <= 24'd0;
      frozen_q <= 1'b0;
      ovf_q    <= 1'b0;
      sec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs1_q    <= cs1_d;
      cs10_q   <= cs10_d;
      s1_q     <= s1_d;
      s10_q    <= s10_d;
      m1_q     <= m1_d;
      m10_q    <= m10_d;
      snap_q   <= snap_d;
      frozen_q <= frozen_d;
      ovf_q    <= ovf_d;
      sec_q    <= sec_d;
    end
  end

  assign disp      = frozen_q ? snap_q : {m10_q, m1_q, s10_q, s1_q, cs10_q, cs1_q};
  assign running   = (state_q == ST_RUN);
  assign frozen    = frozen_q;
  assign overflow  = ovf_q;
  assign sec_pulse = sec_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//   Directed bench for stopwatch_counter. Two instances (MIN_MAX = 99 and
//   MIN_MAX = 1) share one stimulus stream. A reference model keeps elapsed
//   time as a plain centisecond integer per instance and converts it to BCD
//   with division; a compare process checks every output on each falling
//   edge, and literal expectations pin the model at key points.
module tb_stopwatch_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;

  always #5 clk = ~clk;

  logic [23:0] disp0, disp1;
  logic        run0, run1, frz0, frz1, ovf0, ovf1, sec0, sec1;
  logic [1:0]  st0, st1;

  stopwatch_counter dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp(disp0), .running(run0), .frozen(frz0),
    .overflow(ovf0), .sec_pulse(sec0), .state_o(st0)
  );

  stopwatch_counter #(.MIN_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .disp(disp1), .running(run1), .frozen(frz1),
    .overflow(ovf1), .sec_pulse(sec1), .state_o(st1)
  );

  int checks = 0;
  int errors = 0;
  int sec_seen = 0;
  logic chk_en = 1'b0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 pause (model's own notion, not the DUT encoding)
  int m_mode[2];
  int m_total[2];
  int m_snap[2];
  bit m_frozen[2];
  bit m_ovf[2];
  bit m_sec[2];
  int m_max[2] = '{99, 1};

  function automatic logic [23:0] to_bcd(int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_total[k] = 0; m_snap[k] = 0;
      m_frozen[k] = 0; m_ovf[k] = 0; m_sec[k] = 0;
    end
  endtask

  task automatic model_step(bit t, bit ss, bit cl, bit lp);
    for (int k = 0; k < 2; k++) begin
      int  pre;
      bit  clr_ok;
      pre    = m_mode[k];
      clr_ok = cl && (pre != 1);
      m_sec[k] = 0;
      if (clr_ok) begin
        m_total[k] = 0; m_ovf[k] = 0; m_snap[k] = 0; m_frozen[k] = 0;
        m_mode[k] = 0;
      end else begin
        if (t && pre == 1) begin
          m_sec[k] = (m_total[k] % 100 == 99);
          m_total[k] = m_total[k] + 1;
          if (m_total[k] == (m_max[k] + 1) * 6000) begin
            m_total[k] = 0;
            m_ovf[k] = 1;
          end
        end
        if (ss) m_mode[k] = (pre == 1) ? 2 : 1;
        if (lp && pre != 0) begin
          if (!m_frozen[k]) begin
            m_snap[k] = m_total[k];
            m_frozen[k] = 1;
          end else begin
            m_frozen[k] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [23:0] e0, e1;
      e0 = to_bcd(m_frozen[0] ? m_snap[0] : m_total[0]);
      e1 = to_bcd(m_frozen[1] ? m_snap[1] : m_total[1]);
      chk("disp0", 32'(disp0), 32'(e0));
      chk("disp1", 32'(disp1), 32'(e1));
      chk("running0", 32'(run0), 32'(m_mode[0] == 1));
      chk("running1", 32'(run1), 32'(m_mode[1] == 1));
      chk("frozen0", 32'(frz0), 32'(m_frozen[0]));
      chk("frozen1", 32'(frz1), 32'(m_frozen[1]));
      chk("overflow0", 32'(ovf0), 32'(m_ovf[0]));
      chk("overflow1", 32'(ovf1), 32'(m_ovf[1]));
      chk("sec_pulse0", 32'(sec0), 32'(m_sec[0]));
      chk("sec_pulse1", 32'(sec1), 32'(m_sec[1]));
      if (sec0) sec_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns 1 time unit after the next one.
  task automatic step(bit t, bit ss, bit cl, bit lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_step(t, ss, cl, lp);
    @(negedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_disp", 32'(disp0), 32'h0);
    chk("rst_flags", {28'd0, run0, frz0, ovf0, sec0}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // start, 150 ticks
    step(0, 1, 0, 0);
    sec_seen = 0;
    run_ticks(150);
    chk("t150_disp", 32'(disp0), 32'h000150);
    chk("t150_running", 32'(run0), 32'h1);
    chk("t150_secs", 32'(sec_seen), 32'd1);

    // minute rollover
    run_ticks(5849);
    chk("t5999_disp", 32'(disp0), 32'h005999);
    run_ticks(1);
    chk("t6000_disp", 32'(disp0), 32'h010000);
    chk("t6000_sec", 32'(sec0), 32'h1);
    step(0, 0, 0, 0);
    chk("t6000_sec_off", 32'(sec0), 32'h0);

    // MIN_MAX=1 wrap and overflow
    run_ticks(5999);
    chk("t11999_disp1", 32'(disp1), 32'h015999);
    run_ticks(1);
    chk("wrap_disp1", 32'(disp1), 32'h000000);
    chk("wrap_ovf1", 32'(ovf1), 32'h1);
    chk("nowrap_disp0", 32'(disp0), 32'h020000);
    chk("nowrap_ovf0", 32'(ovf0), 32'h0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("clr_ovf1", 32'(ovf1), 32'h0);
    chk("clr_state1", 32'(st1), 32'h0);

    // lap with same-cycle tick; tick while entering RUN is not counted
    step(1, 1, 0, 0);
    chk("enter_run_disp", 32'(disp0), 32'h0);
    run_ticks(10);
    step(1, 0, 0, 1);
    chk("lap_disp", 32'(disp0), 32'h000011);
    chk("lap_frozen", 32'(frz0), 32'h1);
    run_ticks(50);
    chk("lap_hold", 32'(disp0), 32'h000011);
    step(0, 0, 0, 1);
    chk("unlap_disp", 32'(disp0), 32'h000061);
    chk("unlap_frozen", 32'(frz0), 32'h0);

    // clear in RUN ignored; tick while leaving RUN is counted
    step(0, 0, 1, 0);
    chk("run_clr_ign", 32'(disp0), 32'h000061);
    step(1, 1, 0, 0);
    chk("leave_run_disp", 32'(disp0), 32'h000062);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("pause_tick_ign", 32'(disp0), 32'h000062);
    step(0, 1, 1, 0);
    chk("pause_both_disp", 32'(disp0), 32'h0);
    chk("pause_both_run", 32'(run0), 32'h0);
    step(0, 0, 0, 1);
    chk("idle_lap_ign", 32'(frz0), 32'h0);
    step(0, 1, 1, 0);
    chk("idle_both_run", 32'(run0), 32'h0);

    // asynchronous reset mid-count
    step(0, 1, 0, 0);
    run_ticks(1234);
    chk("t1234_disp", 32'(disp0), 32'h001234);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_disp", 32'(disp0), 32'h0);
    chk("arst_flags", {28'd0, run0, frz0, ovf0, sec0}, 32'h0);
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    run_ticks(20);
    chk("idle_ticks_disp", 32'(disp0), 32'h0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
